// File: rtl/s2p_param.sv
// Serial-to-parallel converter: assembles WIDTH qualified serial bits into a word
// held on a registered valid/ready output, flagging words dropped while one is pending.
module s2p_param #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             data,
  input  logic             vld,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             overrun_q, overrun_d;
  logic             complete;

  always_comb begin
    if (LSB_FIRST) shifted = {data, sh_q[WIDTH-1:1]};
    else           shifted = {sh_q[WIDTH-2:0], data};
  end

  assign complete = vld && (cnt_q == CNT_LAST);

  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    overrun_d  = overrun_q;
    if (clr) begin
      sh_d       = '0;
      cnt_d      = '0;
      dout_d     = '0;
      dout_vld_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      if (dout_vld_q && dout_rdy) dout_vld_d = 1'b0;
      if (vld) begin
        sh_d  = shifted;
        cnt_d = complete ? '0 : cnt_q + CW'(1);
      end
      // A word completing into a full, unaccepted output is lost, not queued.
      if (complete) begin
        if (!dout_vld_q || dout_rdy) begin
          dout_d     = shifted;
          dout_vld_d = 1'b1;
        end else begin
          overrun_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign overrun  = overrun_q;

endmodule
